prefetcher_ar_arbiter: RTL and testbench
========================================

# prefetcher_ar_arbiter

Arbitrates the single downstream AXI AR master port between demand reads and prefetch read requests. Demand reads come through the AR pass-through path; prefetch requests are issued by the prefetcher controller. It sits between the prefetcher top-level AR select logic and the memory-side AR port. It registers the winning request, bounds the number of in-flight prefetch bursts, and keeps prefetch traffic from starving while demand traffic is saturated.

## Interface
- ADDR_BITS, 64, request address width
- BURST_LEN_WIDTH, 8, AXI arlen width
- TID_WIDTH, 4, AXI arid width
- STARVE_WIDTH, 4, starvation counter / limit width
- LOG_MAX_PF, 3, width of the prefetch outstanding counter is LOG_MAX_PF+1
- Clock and reset: a single clock, `clk`; reset `resetN` is asynchronous and active-low.
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- en  in  1  prefetch arbitration enable; when 0, prefetch is never granted
- flush  in  1  blocks new prefetch grants this cycle
- d_ar_valid / d_ar_ready  in / out  1 / 1  demand request handshake
- d_ar_len, d_ar_addr, d_ar_id  in  BURST_LEN_WIDTH, ADDR_BITS, TID_WIDTH  demand payload
- p_ar_valid / p_ar_ready  in / out  1 / 1  prefetch request handshake
- p_ar_len, p_ar_addr, p_ar_id  in  as demand  prefetch payload
- m_ar_valid / m_ar_ready  out / in  1 / 1  downstream handshake
- m_ar_len, m_ar_addr, m_ar_id  out  as demand  registered payload
- m_ar_src  out  1  0 = demand, 1 = prefetch, valid while m_ar_valid
- pf_done  in  1  one-cycle pulse: one prefetch burst completed (last beat received)
- crs_maxPf  in  LOG_MAX_PF+1  maximum in-flight prefetch bursts (0 means prefetch disabled)
- crs_starveLimit  in  STARVE_WIDTH  consecutive demand grants tolerated while a prefetch waits
- pfOutstanding  out  LOG_MAX_PF+1  current in-flight prefetch count

## Operation
- One-entry output register, states EMPTY and FULL; m_ar_valid = FULL.
- Load slot: `canLoad = EMPTY | (FULL & m_ar_ready)`.
- Prefetch eligibility: `pfOk = p_ar_valid & en & ~flush & (pfOutstanding < crs_maxPf)`.
- Grant priority: demand wins, except when `pfOk & starveCnt >= crs_starveLimit`, in which case prefetch wins.
- Handshakes:
  - `d_ar_ready = canLoad & grantD`.
  - `p_ar_ready = canLoad & grantP`.
  - The ready signals are combinational from the input valids, m_ar_ready and state. There is never a combinational path from valid to ready of the same source beyond the grant.
- On any grant, the output register captures the winner's payload and sets m_ar_src. State becomes or stays FULL.
- If FULL, m_ar_ready=1 and there is no grant, state goes to EMPTY.
- While FULL and m_ar_ready=0, payload and m_ar_src are held stable.
- starveCnt:
  - Increments (saturating at all-ones) on a demand grant while pfOk.
  - Clears on a prefetch grant.
  - Otherwise holds.
- pfOutstanding:
  - +1 on m_ar handshake with m_ar_src=1.
  - −1 on pf_done.
  - Both in the same cycle: unchanged.
  - pf_done at 0 is ignored and does not underflow.
- flush or en=0 does not retract a prefetch already in the output register, so the AXI valid-stability rule holds.

## Timing
- Reset values:
  - m_ar_valid, m_ar_src, m_ar_len, m_ar_addr, m_ar_id: 0
  - d_ar_ready, p_ar_ready: 0 (state EMPTY, no valids)
  - pfOutstanding: 0; starveCnt: 0
- Latency: a source handshake in cycle N gives m_ar_valid=1 with that payload in cycle N+1.
- Throughput is 1 request/cycle when m_ar_ready stays high (back-to-back load on the handshake cycle).
- pfOutstanding updates one cycle after the m_ar handshake or pf_done.
- The crs_* inputs are sampled every cycle. Lowering crs_maxPf below pfOutstanding only blocks new grants.
- Asserting resetN mid-burst drops the held request immediately (asynchronous). The surrounding prefetcher is reset in the same cycle.

## Configuration
- PR_ARB_STARVE_EN defined: starvation counter and crs_starveLimit are active, as described above.
- PR_ARB_STARVE_EN undefined:
  - Strict demand priority: a prefetch is granted only when d_ar_valid=0 (and pfOk).
  - starveCnt logic is removed and crs_starveLimit is ignored.

## Test plan
- After reset, assert d_ar_valid with addr 0x1000, id 3, m_ar_ready=1 → d_ar_ready=1 in cycle 0. In cycle 1: m_ar_valid=1, m_ar_addr=0x1000, m_ar_id=3, m_ar_src=0.
- Stall: with m_ar_ready=0 for 5 cycles while FULL → payload stable for all 5 cycles, d_ar_ready=p_ar_ready=0. With m_ar_ready=1 and no valids → EMPTY next cycle.
- Starvation (PR_ARB_STARVE_EN, crs_starveLimit=2): d_ar_valid and p_ar_valid held high, m_ar_ready=1 → m_ar_src sequence 0,0,1,0,0,1. Without the macro → all 0.
- Outstanding cap (crs_maxPf=2): three prefetch requests, no pf_done → two issued, pfOutstanding=2, p_ar_ready stays 0. A pf_done pulse releases the third.
- Simultaneous: a prefetch m_ar handshake and pf_done in the same cycle with pfOutstanding=1 → remains 1. pf_done at 0 → remains 0.
- Flush: flush=1 with a prefetch held FULL and m_ar_ready=0 → m_ar_valid stays 1 and the request completes. A new p_ar_valid during flush gets p_ar_ready=0.

Source files
------------

// File: rtl/prefetcher_ar_arbiter.sv
// Arbitrates demand vs prefetch AR requests into one registered downstream AR slot (PR_ARB_STARVE_EN enables anti-starvation).
// Latency: source handshake in cycle N -> m_ar_valid with payload in cycle N+1; 1 req/cycle while m_ar_ready is high.
// Backpressure: m_ar_ready low while FULL holds the payload and drops both source readies.
module prefetcher_ar_arbiter #(
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 4,
    parameter int STARVE_WIDTH    = 4,
    parameter int LOG_MAX_PF      = 3
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       d_ar_valid,
    output logic                       d_ar_ready,
    input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
    input  logic [ADDR_BITS-1:0]       d_ar_addr,
    input  logic [TID_WIDTH-1:0]       d_ar_id,
    input  logic                       p_ar_valid,
    output logic                       p_ar_ready,
    input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
    input  logic [ADDR_BITS-1:0]       p_ar_addr,
    input  logic [TID_WIDTH-1:0]       p_ar_id,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [ADDR_BITS-1:0]       m_ar_addr,
    output logic [TID_WIDTH-1:0]       m_ar_id,
    output logic                       m_ar_src,
    input  logic                       pf_done,
    input  logic [LOG_MAX_PF:0]        crs_maxPf,
    input  logic [STARVE_WIDTH-1:0]    crs_starveLimit,
    output logic [LOG_MAX_PF:0]        pfOutstanding
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic                       src_q, src_d;
    logic [LOG_MAX_PF:0]        pf_out_q, pf_out_d;

    logic can_load, pf_ok, grant_d, grant_p, load, m_hs, pf_inc, pf_dec;

`ifdef PR_ARB_STARVE_EN
    logic [STARVE_WIDTH-1:0] starve_q, starve_d;
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^crs_starveLimit;
`endif

    always_comb begin
        can_load = (state_q == EMPTY) | m_ar_ready;
        pf_ok    = p_ar_valid & en & ~flush & (pf_out_q < crs_maxPf);
`ifdef PR_ARB_STARVE_EN
        grant_p  = pf_ok & (~d_ar_valid | (starve_q >= crs_starveLimit));
`else
        grant_p  = pf_ok & ~d_ar_valid;
`endif
        grant_d  = d_ar_valid & ~grant_p;
        load     = can_load & (grant_d | grant_p);
        m_hs     = (state_q == FULL) & m_ar_ready;

        state_d = state_q;
        len_d   = len_q;
        addr_d  = addr_q;
        id_d    = id_q;
        src_d   = src_q;
        if (load) begin
            state_d = FULL;
            src_d   = grant_p;
            len_d   = grant_p ? p_ar_len  : d_ar_len;
            addr_d  = grant_p ? p_ar_addr : d_ar_addr;
            id_d    = grant_p ? p_ar_id   : d_ar_id;
        end else if (m_hs) begin
            state_d = EMPTY;
        end

        // A pf_done with nothing outstanding is dropped so the count never wraps.
        pf_inc   = m_hs & src_q;
        pf_dec   = pf_done & (pf_out_q != '0);
        pf_out_d = pf_out_q;
        if (pf_inc && !pf_dec)
            pf_out_d = pf_out_q + 1'b1;
        else if (pf_dec && !pf_inc)
            pf_out_d = pf_out_q - 1'b1;

`ifdef PR_ARB_STARVE_EN
        starve_d = starve_q;
        if (can_load && grant_p)
            starve_d = '0;
        else if (can_load && grant_d && pf_ok && (starve_q != '1))
            starve_d = starve_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= EMPTY;
            len_q    <= '0;
            addr_q   <= '0;
            id_q     <= '0;
            src_q    <= 1'b0;
            pf_out_q <= '0;
`ifdef PR_ARB_STARVE_EN
            starve_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            id_q     <= id_d;
            src_q    <= src_d;
            pf_out_q <= pf_out_d;
`ifdef PR_ARB_STARVE_EN
            starve_q <= starve_d;
`endif
        end
    end

    assign m_ar_valid    = (state_q == FULL);
    assign m_ar_len      = len_q;
    assign m_ar_addr     = addr_q;
    assign m_ar_id       = id_q;
    assign m_ar_src      = src_q;
    assign d_ar_ready    = can_load & grant_d;
    assign p_ar_ready    = can_load & grant_p;
    assign pfOutstanding = pf_out_q;

endmodule

// File: tb/tb_prefetcher_ar_arbiter.sv
// Scoreboarded bench for prefetcher_ar_arbiter: source handshakes push expected AR beats, downstream handshakes pop them.
module tb_prefetcher_ar_arbiter;

    typedef struct packed {
        logic        src;
        logic [7:0]  len;
        logic [63:0] addr;
        logic [3:0]  id;
    } ar_t;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        en = 1'b0, flush = 1'b0;
    logic        d_ar_valid = 1'b0, p_ar_valid = 1'b0, m_ar_ready = 1'b0, pf_done = 1'b0;
    logic        d_ar_ready, p_ar_ready, m_ar_valid, m_ar_src;
    logic [7:0]  d_ar_len = '0, p_ar_len = '0, m_ar_len;
    logic [63:0] d_ar_addr = '0, p_ar_addr = '0, m_ar_addr;
    logic [3:0]  d_ar_id = '0, p_ar_id = '0, m_ar_id;
    logic [3:0]  crs_maxPf = 4'd8, crs_starveLimit = 4'd2, pfOutstanding;

    int errors = 0;
    int checks = 0;
    ar_t sb_q[$];

    prefetcher_ar_arbiter dut (
        .clk(clk), .resetN(resetN), .en(en), .flush(flush),
        .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready), .d_ar_len(d_ar_len),
        .d_ar_addr(d_ar_addr), .d_ar_id(d_ar_id),
        .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready), .p_ar_len(p_ar_len),
        .p_ar_addr(p_ar_addr), .p_ar_id(p_ar_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_len(m_ar_len),
        .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id), .m_ar_src(m_ar_src),
        .pf_done(pf_done), .crs_maxPf(crs_maxPf), .crs_starveLimit(crs_starveLimit),
        .pfOutstanding(pfOutstanding)
    );

    always #5 clk = ~clk;

    // Scoreboard: sampled mid-cycle, so handshakes seen here are the ones the next posedge commits.
    always @(negedge clk) begin
        if (resetN) begin
            if (m_ar_valid && m_ar_ready) begin
                ar_t exp_ar;
                ar_t got_ar;
                got_ar = '{src: m_ar_src, len: m_ar_len, addr: m_ar_addr, id: m_ar_id};
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got %h, required no beat", got_ar);
                end else begin
                    exp_ar = sb_q.pop_front();
                    if (got_ar !== exp_ar) begin
                        errors++;
                        $display("FAIL sb_beat: got %h, required %h", got_ar, exp_ar);
                    end
                end
            end
            if (d_ar_valid && d_ar_ready)
                sb_q.push_back('{src: 1'b0, len: d_ar_len, addr: d_ar_addr, id: d_ar_id});
            if (p_ar_valid && p_ar_ready)
                sb_q.push_back('{src: 1'b1, len: p_ar_len, addr: p_ar_addr, id: p_ar_id});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 0; pf_done = 0;
        flush = 0; en = 1; crs_maxPf = 4'd8; crs_starveLimit = 4'd2;
        resetN = 0;
        sb_q.delete();
        cyc();
        resetN = 1;
        cyc();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        resetN = 0;
        d_ar_valid = 0; p_ar_valid = 0;
        #3;
        checks++;
        if ({m_ar_valid, m_ar_src, m_ar_len, m_ar_addr, m_ar_id, d_ar_ready, p_ar_ready, pfOutstanding} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b src=%b len=%h addr=%h id=%h dr=%b pr=%b pfo=%0d, required all 0",
                     m_ar_valid, m_ar_src, m_ar_len, m_ar_addr, m_ar_id, d_ar_ready, p_ar_ready, pfOutstanding);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        m_ar_ready = 1; d_ar_valid = 1; d_ar_addr = 64'h1000; d_ar_id = 4'd3; d_ar_len = 8'd7;
        @(negedge clk);
        checks++;
        if (d_ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_d_ready: got %b, required 1", d_ar_ready);
        end
        cyc();
        d_ar_valid = 0;
        @(negedge clk);
        checks++;
        if ({m_ar_valid, m_ar_addr, m_ar_id, m_ar_src} !== {1'b1, 64'h1000, 4'd3, 1'b0}) begin
            errors++;
            $display("FAIL basic_out: valid=%b addr=%h id=%h src=%b, required 1 1000 3 0",
                     m_ar_valid, m_ar_addr, m_ar_id, m_ar_src);
        end
        cyc();
        check_drained("basic");
    endtask

    task automatic test_stall();
        do_reset();
        d_ar_valid = 1; d_ar_addr = 64'h2222; d_ar_id = 4'd5; d_ar_len = 8'd1;
        cyc();
        d_ar_addr = 64'h3333; d_ar_id = 4'd6; p_ar_valid = 1; p_ar_addr = 64'h4444;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({m_ar_valid, m_ar_addr, m_ar_id, d_ar_ready, p_ar_ready} !== {1'b1, 64'h2222, 4'd5, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b addr=%h id=%h dr=%b pr=%b, required 1 2222 5 0 0",
                         i, m_ar_valid, m_ar_addr, m_ar_id, d_ar_ready, p_ar_ready);
            end
            cyc();
        end
        d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 1;
        cyc();
        @(negedge clk);
        checks++;
        if (m_ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: m_ar_valid=%b, required 0", m_ar_valid);
        end
        check_drained("stall");
    endtask

    task automatic test_starvation();
        logic [5:0] exp_src;
`ifdef PR_ARB_STARVE_EN
        exp_src = 6'b100100;
`else
        exp_src = 6'b000000;
`endif
        do_reset();
        m_ar_ready = 1;
        d_ar_valid = 1; d_ar_addr = 64'hD000; d_ar_id = 4'd1;
        p_ar_valid = 1; p_ar_addr = 64'hE000; p_ar_id = 4'd2;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                checks++;
                if ({m_ar_valid, m_ar_src} !== {1'b1, exp_src[k-1]}) begin
                    errors++;
                    $display("FAIL starve_src[%0d]: valid=%b src=%b, required 1 %b",
                             k - 1, m_ar_valid, m_ar_src, exp_src[k-1]);
                end
            end
            cyc();
        end
        d_ar_valid = 0; p_ar_valid = 0;
        cyc(); cyc();
        check_drained("starve");
    endtask

    task automatic send_pf(input logic [63:0] addr);
        bit got = 0;
        p_ar_valid = 1; p_ar_addr = addr; p_ar_id = addr[3:0];
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p_ar_ready;
            cyc();
        end
        p_ar_valid = 0;
        if (!got) begin
            errors++; checks++;
            $display("FAIL send_pf_timeout: p_ar_ready=0, required 1 within 20 cycles");
        end
        cyc(); cyc();
    endtask

    task automatic test_outstanding_cap();
        do_reset();
        crs_maxPf = 4'd2; m_ar_ready = 1;
        send_pf(64'hA001);
        send_pf(64'hA002);
        p_ar_valid = 1; p_ar_addr = 64'hA003; p_ar_id = 4'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({pfOutstanding, p_ar_ready} !== {4'd2, 1'b0}) begin
                errors++;
                $display("FAIL cap_block[%0d]: pfo=%0d pr=%b, required 2 0", i, pfOutstanding, p_ar_ready);
            end
            cyc();
        end
        pf_done = 1;
        cyc();
        pf_done = 0;
        @(negedge clk);
        checks++;
        if ({pfOutstanding, p_ar_ready} !== {4'd1, 1'b1}) begin
            errors++;
            $display("FAIL cap_release: pfo=%0d pr=%b, required 1 1", pfOutstanding, p_ar_ready);
        end
        cyc();
        p_ar_valid = 0;
        cyc(); cyc();
        checks++;
        if (pfOutstanding !== 4'd2) begin
            errors++;
            $display("FAIL cap_third: pfo=%0d, required 2", pfOutstanding);
        end
        check_drained("cap");
    endtask

    task automatic test_simultaneous();
        do_reset();
        m_ar_ready = 1;
        pf_done = 1;
        cyc();
        pf_done = 0;
        @(negedge clk);
        checks++;
        if (pfOutstanding !== 4'd0) begin
            errors++;
            $display("FAIL sim_underflow: pfo=%0d, required 0", pfOutstanding);
        end
        cyc();
        send_pf(64'hB001);
        p_ar_valid = 1; p_ar_addr = 64'hB002; p_ar_id = 4'd2;
        @(negedge clk);
        checks++;
        if (p_ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL sim_pready: got %b, required 1", p_ar_ready);
        end
        cyc();
        p_ar_valid = 0; pf_done = 1;
        @(negedge clk);
        checks++;
        if ({m_ar_valid, m_ar_src, pfOutstanding} !== {1'b1, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL sim_pre: valid=%b src=%b pfo=%0d, required 1 1 1", m_ar_valid, m_ar_src, pfOutstanding);
        end
        cyc();
        pf_done = 0;
        @(negedge clk);
        checks++;
        if (pfOutstanding !== 4'd1) begin
            errors++;
            $display("FAIL sim_both: pfo=%0d, required 1", pfOutstanding);
        end
        cyc();
        check_drained("sim");
    endtask

    task automatic test_flush();
        do_reset();
        p_ar_valid = 1; p_ar_addr = 64'hC001; p_ar_id = 4'd9;
        cyc();
        p_ar_valid = 0; flush = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m_ar_valid, m_ar_src, m_ar_addr} !== {1'b1, 1'b1, 64'hC001}) begin
                errors++;
                $display("FAIL flush_hold[%0d]: valid=%b src=%b addr=%h, required 1 1 c001",
                         i, m_ar_valid, m_ar_src, m_ar_addr);
            end
            cyc();
        end
        p_ar_valid = 1; p_ar_addr = 64'hC002; m_ar_ready = 1;
        @(negedge clk);
        checks++;
        if ({m_ar_valid, p_ar_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_block: valid=%b pr=%b, required 1 0", m_ar_valid, p_ar_ready);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({m_ar_valid, p_ar_ready} !== 2'b00) begin
            errors++;
            $display("FAIL flush_done: valid=%b pr=%b, required 0 0", m_ar_valid, p_ar_ready);
        end
        cyc();
        p_ar_valid = 0; flush = 0;
        cyc();
        check_drained("flush");
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_stall();
        test_starvation();
        test_outstanding_cap();
        test_simultaneous();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
